// File: rtl/sg_key_controller.sv
// sg_key_controller
//
// Front end for the signal generator's four parameter keys (wave, amplitude,
// phase, frequency). It synchronises and debounces the raw active-low board
// keys and lets exactly one key own the controls at a time. The owner's press
// becomes a single-cycle *_ctrl pulse. With auto-repeat built in, holding the
// owner produces further pulses.
//
// Build option: define SG_KEY_AUTOREPEAT_EN to include the auto-repeat timer
// and the REPEAT state. Without it, each press gives exactly one pulse.
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   key_n[3:0]  in   raw keys, active-low, asynchronous (3=W, 2=A, 1=P, 0=F)
//   W_ctrl      out  one-cycle wave-step pulse
//   A_ctrl      out  one-cycle amplitude-step pulse
//   P_ctrl      out  one-cycle phase-step pulse
//   F_ctrl      out  one-cycle frequency-step pulse
//   busy        out  high while a key owns the controller
//   active_key  out  index of the owning key, holds its value when idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no owner, waiting for any debounced press
// S_HOLD     | owner held, first pulse sent, waiting for repeat delay
// S_REPEAT   | owner held, pulsing every repeat period (auto-repeat only)
// S_WAIT_REL | owner released, waiting until every key is released

module sg_key_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    output logic       W_ctrl,
    output logic       A_ctrl,
    output logic       P_ctrl,
    output logic       F_ctrl,
    output logic       busy,
    output logic [1:0] active_key
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef SG_KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_LD  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LD = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] timer_q;
`else
    // Repeat timing has no effect in this build.
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_REPEAT   = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;
    logic [3:0]      db_q;
    logic [3:0]      db_d;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];

    state_t          state_q;
    logic [3:0]      pulse_q;
    logic            busy_q;
    logic [1:0]      active_key_q;

    logic            any_pressed;
    logic            all_released;
    logic            owner_released;
    logic [1:0]      owner_idx;

    // Two-flop synchroniser; released (1) out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // The counter runs only while the synchronised level disagrees with the
    // debounced one. The edge that would reach DEBOUNCE_CYCLES flips db instead.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q <= '1;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign any_pressed    = ~&db_q;
    assign all_released   = &db_q;
    assign owner_released = db_q[active_key_q];

    // Priority W > A > P > F.
    always_comb begin
        owner_idx = 2'd0;
        if (!db_q[3]) begin
            owner_idx = 2'd3;
        end else if (!db_q[2]) begin
            owner_idx = 2'd2;
        end else if (!db_q[1]) begin
            owner_idx = 2'd1;
        end
    end

    // When the owner was the last key down, the WAIT_REL exit condition already
    // holds. The FSM goes straight to IDLE, so busy falls one cycle after the
    // final release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pulse_q      <= '0;
            busy_q       <= 1'b0;
            active_key_q <= '0;
`ifdef SG_KEY_AUTOREPEAT_EN
            timer_q      <= '0;
`endif
        end else begin
            pulse_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (any_pressed) begin
                        state_q            <= S_HOLD;
                        pulse_q[owner_idx] <= 1'b1;
                        active_key_q       <= owner_idx;
                        busy_q             <= 1'b1;
`ifdef SG_KEY_AUTOREPEAT_EN
                        timer_q            <= RPT_DELAY_LD;
`endif
                    end
                end
                S_HOLD: begin
                    if (owner_released) begin
                        state_q <= all_released ? S_IDLE : S_WAIT_REL;
                        busy_q  <= !all_released;
                    end
`ifdef SG_KEY_AUTOREPEAT_EN
                    else if (timer_q == '0) begin
                        pulse_q[active_key_q] <= 1'b1;
                        timer_q               <= RPT_PERIOD_LD;
                        state_q               <= S_REPEAT;
                    end else begin
                        timer_q <= timer_q - RPT_W'(1);
                    end
`endif
                end
`ifdef SG_KEY_AUTOREPEAT_EN
                S_REPEAT: begin
                    if (owner_released) begin
                        state_q <= all_released ? S_IDLE : S_WAIT_REL;
                        busy_q  <= !all_released;
                    end else if (timer_q == '0) begin
                        pulse_q[active_key_q] <= 1'b1;
                        timer_q               <= RPT_PERIOD_LD;
                    end else begin
                        timer_q <= timer_q - RPT_W'(1);
                    end
                end
`endif
                S_WAIT_REL: begin
                    if (all_released) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign W_ctrl     = pulse_q[3];
    assign A_ctrl     = pulse_q[2];
    assign P_ctrl     = pulse_q[1];
    assign F_ctrl     = pulse_q[0];
    assign busy       = busy_q;
    assign active_key = active_key_q;

endmodule

// File: tb/tb_sg_key_controller.sv
// Bench for sg_key_controller (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8). A reference model tracks the expected outputs every cycle.
// Directed checks pin the key timings of each scenario.

module tb_sg_key_controller;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef SG_KEY_AUTOREPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_n;
    logic       W_ctrl, A_ctrl, P_ctrl, F_ctrl, busy;
    logic [1:0] active_key;

    sg_key_controller #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .W_ctrl    (W_ctrl),
        .A_ctrl    (A_ctrl),
        .P_ctrl    (P_ctrl),
        .F_ctrl    (F_ctrl),
        .busy      (busy),
        .active_key(active_key)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_OWN, M_WAIT} mstate_t;

    int         n_assert;
    int         n_fail;
    int         cyc;
    int         base;
    int         pcnt [4];
    int         poff [$];
    bit         busy_seen;

    logic [3:0] m_hist [$];
    logic [3:0] m_db;
    mstate_t    m_state;
    logic [3:0] m_pulse;
    logic       m_busy;
    logic [1:0] m_ak;
    int         m_t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic begin_scn();
        base = cyc;
        for (int i = 0; i < 4; i++) pcnt[i] = 0;
        poff.delete();
        busy_seen = 1'b0;
    endtask

    // Model of the owner FSM: pulses depend only on elapsed time since the
    // first pulse of the current ownership.
    task automatic model_fsm(input logic [3:0] db);
        int owner;
        int dt;
        m_pulse = '0;
        case (m_state)
            M_IDLE: begin
                if (db != 4'hF) begin
                    owner = 0;
                    for (int i = 0; i < 4; i++) if (!db[i]) owner = i;
                    m_pulse[owner] = 1'b1;
                    m_ak    = 2'(owner);
                    m_busy  = 1'b1;
                    m_t0    = cyc;
                    m_state = M_OWN;
                end
            end
            M_OWN: begin
                dt = cyc - m_t0;
                if (db[m_ak]) begin
                    if (db == 4'hF) begin
                        m_state = M_IDLE;
                        m_busy  = 1'b0;
                    end else begin
                        m_state = M_WAIT;
                    end
                end else if (REPEAT_ON && dt >= RD && ((dt - RD) % RP) == 0) begin
                    m_pulse[m_ak] = 1'b1;
                end
            end
            default: begin
                if (db == 4'hF) begin
                    m_state = M_IDLE;
                    m_busy  = 1'b0;
                end
            end
        endcase
    endtask

    // One clock: drive inputs, advance the model, check all outputs.
    // The debounced level flips once the last D synchronised samples all
    // disagree with it. Synchronised value seen at edge n is the key sampled
    // at edge n-2.
    task automatic step(input logic [3:0] k, input logic r);
        logic [3:0] db_old;
        bit         all_diff;
        key_n = k;
        rst_n = r;
        @(posedge clk);
        cyc++;
        if (!r) begin
            m_hist.delete();
            for (int i = 0; i <= D; i++) m_hist.push_back(4'hF);
            m_db    = 4'hF;
            m_state = M_IDLE;
            m_pulse = '0;
            m_busy  = 1'b0;
            m_ak    = '0;
        end else begin
            db_old = m_db;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    if (m_hist[m_hist.size() - 1 - j][i] == m_db[i]) all_diff = 1'b0;
                end
                if (all_diff) m_db[i] = ~m_db[i];
            end
            m_hist.push_back(k);
            if (m_hist.size() > D + 2) void'(m_hist.pop_front());
            model_fsm(db_old);
        end
        #1;
        chk("pulses", {W_ctrl, A_ctrl, P_ctrl, F_ctrl}, m_pulse);
        chk("busy", busy, m_busy);
        chk("active_key", active_key, m_ak);
        if (busy) busy_seen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ({W_ctrl, A_ctrl, P_ctrl, F_ctrl} & (4'b0001 << i)) begin
                pcnt[i]++;
                poff.push_back(cyc - base);
            end
        end
    endtask

    initial begin
        int exp_off [$];
        logic [3:0] v;
        int len;

        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        key_n    = 4'hF;
        rst_n    = 1'b0;

        // Reset
        repeat (3) step(4'hF, 1'b0);
        chk("reset_busy", busy, 0);
        chk("reset_active_key", active_key, 0);
        chk("reset_pulses", {W_ctrl, A_ctrl, P_ctrl, F_ctrl}, 0);
        repeat (2) step(4'hF, 1'b1);

        // Clean press on W, released after 10 cycles
        begin_scn();
        for (int i = 1; i <= 10; i++) begin
            step(4'b0111, 1'b1);
            if (i == 7) chk("clean_busy_rise", busy, 1);
        end
        chk("clean_w_count", pcnt[3], 1);
        chk("clean_total", poff.size(), 1);
        chk("clean_first_edge", (poff.size() > 0) ? poff[0] : -1, 7);
        for (int i = 11; i <= 20; i++) begin
            step(4'hF, 1'b1);
            if (i == 16) chk("clean_busy_held", busy, 1);
            if (i == 17) chk("clean_busy_fall", busy, 0);
        end

        // Bounce on A: low 3, high 1, repeating
        begin_scn();
        for (int i = 0; i < 40; i++) step(((i % 4) == 3) ? 4'hF : 4'b1011, 1'b1);
        repeat (8) step(4'hF, 1'b1);
        chk("bounce_a_count", pcnt[2], 0);
        chk("bounce_total", poff.size(), 0);
        chk("bounce_busy_seen", busy_seen, 0);

        // A and P pressed together; release A while P is held
        begin_scn();
        for (int i = 1; i <= 12; i++) begin
            step(4'b1001, 1'b1);
            if (i == 7) chk("simul_active_key", active_key, 2);
        end
        repeat (12) step(4'b1101, 1'b1);
        repeat (10) step(4'hF, 1'b1);
        chk("simul_a_count", pcnt[2], 1);
        chk("simul_p_count", pcnt[1], 0);
        chk("simul_first_edge", (poff.size() > 0) ? poff[0] : -1, 7);
        chk("simul_busy_end", busy, 0);

        // Hold F for 60 cycles
        begin_scn();
        repeat (60) step(4'b1110, 1'b1);
        exp_off.delete();
        exp_off.push_back(7);
        if (REPEAT_ON) begin
            exp_off.push_back(27); exp_off.push_back(35); exp_off.push_back(43);
            exp_off.push_back(51); exp_off.push_back(59);
        end
        chk("repeat_f_count", pcnt[0], exp_off.size());
        for (int k = 0; k < exp_off.size(); k++)
            chk("repeat_edge", (poff.size() > k) ? poff[k] : -1, exp_off[k]);
        repeat (10) step(4'hF, 1'b1);

        // Reset while F is held, F still held after release of reset
        begin_scn();
        for (int i = 1; i <= 45; i++) begin
            step(4'b1110, !(i == 31 || i == 32));
            if (i == 31) begin
                chk("rst_mid_pulses", {W_ctrl, A_ctrl, P_ctrl, F_ctrl}, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_active_key", active_key, 0);
            end
        end
        chk("rst_mid_count", pcnt[0], REPEAT_ON ? 3 : 2);
        chk("rst_mid_last_edge", (poff.size() > 0) ? poff[poff.size() - 1] : -1, 39);
        repeat (10) step(4'hF, 1'b1);

        // Each key alone, F first
        for (int k = 0; k < 4; k++) begin
            begin_scn();
            v = 4'b1111 ^ (4'b0001 << k);
            for (int i = 1; i <= 10; i++) begin
                step(v, 1'b1);
                if (i == 7) chk("sweep_active_key", active_key, k);
            end
            chk("sweep_key_count", pcnt[k], 1);
            chk("sweep_total", poff.size(), 1);
            repeat (10) step(4'hF, 1'b1);
        end

        // Random key patterns
        begin_scn();
        repeat (40) begin
            v   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            repeat (len) step(v, 1'b1);
        end
        repeat (20) step(4'hF, 1'b1);
        chk("random_busy_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
